universal_shift_register: RTL and testbench

//  - Parametrised successor to the fixed 4-bit serial-in shift register: WIDTH-bit universal register.
//  - Modes: hold, shift right, shift left, parallel load.
//  - Shift counter gives word framing: one-cycle pulse after every WIDTH shifts since the last load/reset.
//  - Serial<->parallel conversion stage for serial links and test stimulus paths.

---
 rtl/universal_shift_register.sv | 90 +++++++++
 tb/tb_universal_shift_register.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift right/left, parallel load, with word-framing counter.
// Optional rotate mode (rot_i port) is enabled by defining USR_ROTATE_EN.
module universal_shift_register #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             sdata_r_i,
    input  logic             sdata_l_i,
    input  logic [WIDTH-1:0] pdata_i,
`ifdef USR_ROTATE_EN
    input  logic             rot_i,
`endif
    output logic [WIDTH-1:0] sr_o,
    output logic             sout_r_o,
    output logic             sout_l_o,
    output logic [CW-1:0]    cnt_o,
    output logic             word_done_o
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             word_done_q, word_done_d;
    logic             fill_r, fill_l;

    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        fill_r      = sdata_r_i;
        fill_l      = sdata_l_i;
`ifdef USR_ROTATE_EN
        // Rotating recirculates the bit that falls off instead of taking serial input.
        if (rot_i) begin
            fill_r = sr_q[0];
            fill_l = sr_q[WIDTH-1];
        end
`endif
        if (en_i) begin
            case (mode_t'(mode_i))
                MODE_RIGHT: sr_d = {fill_r, sr_q[WIDTH-1:1]};
                MODE_LEFT:  sr_d = {sr_q[WIDTH-2:0], fill_l};
                MODE_LOAD: begin
                    sr_d  = pdata_i;
                    cnt_d = '0;
                end
                default: ;
            endcase
            // Both shift directions advance the one word counter.
            if (mode_i == MODE_RIGHT || mode_i == MODE_LEFT) begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d       = '0;
                    word_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q        <= RESET_VAL;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign sr_o        = sr_q;
    assign sout_r_o    = sr_q[0];
    assign sout_l_o    = sr_q[WIDTH-1];
    assign cnt_o       = cnt_q;
    assign word_done_o = word_done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Table-driven self-checking bench for universal_shift_register (WIDTH=4, RESET_VAL=0).
// Rotate vectors are included only when USR_ROTATE_EN is defined.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_i;
    logic [1:0] mode_i;
    logic       sdata_r_i;
    logic       sdata_l_i;
    logic [3:0] pdata_i;
    logic       rot_i;
    logic [3:0] sr_o;
    logic       sout_r_o;
    logic       sout_l_o;
    logic [1:0] cnt_o;
    logic       word_done_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       sdr;
        logic       sdl;
        logic       rot;
        logic [3:0] pd;
        logic [3:0] esr;
        logic [1:0] ecnt;
        logic       edone;
    } vec_t;

    vec_t vecs[$];

    universal_shift_register #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .sdata_r_i   (sdata_r_i),
        .sdata_l_i   (sdata_l_i),
        .pdata_i     (pdata_i),
`ifdef USR_ROTATE_EN
        .rot_i       (rot_i),
`endif
        .sr_o        (sr_o),
        .sout_r_o    (sout_r_o),
        .sout_l_o    (sout_l_o),
        .cnt_o       (cnt_o),
        .word_done_o (word_done_o)
    );

    always #5 clk = ~clk;

    function automatic void addVec(input logic rst, input logic en, input logic [1:0] mode,
                                   input logic sdr, input logic sdl, input logic rot,
                                   input logic [3:0] pd, input logic [3:0] esr,
                                   input logic [1:0] ecnt, input logic edone);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.sdr = sdr; v.sdl = sdl; v.rot = rot;
        v.pd = pd; v.esr = esr; v.ecnt = ecnt; v.edone = edone;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] esr,
                               input logic [1:0] ecnt, input logic edone);
        checks += 4;
        if (sr_o !== esr) begin
            failures++;
            $display("[TB] FAIL %s sr_o actual=%b required=%b", tag, sr_o, esr);
        end
        if (cnt_o !== ecnt) begin
            failures++;
            $display("[TB] FAIL %s cnt_o actual=%0d required=%0d", tag, cnt_o, ecnt);
        end
        if (word_done_o !== edone) begin
            failures++;
            $display("[TB] FAIL %s word_done_o actual=%b required=%b", tag, word_done_o, edone);
        end
        if (sout_r_o !== esr[0] || sout_l_o !== esr[3]) begin
            failures++;
            $display("[TB] FAIL %s sout_r/l actual=%b%b required=%b%b",
                     tag, sout_r_o, sout_l_o, esr[0], esr[3]);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        reset     = v.rst;
        en_i      = v.en;
        mode_i    = v.mode;
        sdata_r_i = v.sdr;
        sdata_l_i = v.sdl;
        rot_i     = v.rot;
        pdata_i   = v.pd;
        @(posedge clk);
        #1;
        checkOutput(tag, v.esr, v.ecnt, v.edone);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; en_i = 1'b0; mode_i = 2'b00; sdata_r_i = 1'b0;
        sdata_l_i = 1'b0; rot_i = 1'b0; pdata_i = 4'b0000;

        //     rst en  mode   sdr   sdl   rot   pd       esr      ecnt  edone
        addVec(1, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0);
        addVec(0, 1, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 2'd1, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b0);
        addVec(0, 1, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010, 2'd3, 1'b0);
        addVec(0, 1, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1101, 2'd0, 1'b1);
        addVec(0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 2'd0, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b0);
        addVec(0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 2'd0, 1'b0);
        addVec(0, 0, 2'b01, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0110, 2'd0, 1'b0);
        addVec(0, 0, 2'b01, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0110, 2'd0, 1'b0);
        addVec(0, 0, 2'b11, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0110, 2'd0, 1'b0);
        addVec(0, 1, 2'b00, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0110, 2'd0, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 2'd1, 1'b0);
        addVec(0, 1, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1001, 2'd2, 1'b0);
        addVec(1, 1, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
        addVec(0, 1, 2'b10, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd1, 1'b0);
        addVec(0, 1, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 2'd2, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1);
        addVec(0, 1, 2'b10, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0011, 2'd1, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110, 2'd2, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1100, 2'd3, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 2'd0, 1'b1);
        addVec(0, 0, 2'b10, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 2'd0, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd1, 1'b0);
        addVec(0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111, 2'd1, 1'b0);
`ifdef USR_ROTATE_EN
        addVec(0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 2'd0, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100, 2'd1, 1'b0);
        addVec(0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 2'd0, 1'b0);
        addVec(0, 1, 2'b10, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0011, 2'd1, 1'b0);
        addVec(0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 2'd0, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100, 2'd1, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0110, 2'd2, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0011, 2'd3, 1'b0);
        addVec(0, 1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1001, 2'd0, 1'b1);
        addVec(0, 1, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1100, 2'd1, 1'b0);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: enable gaps inside a word; pulse lands on the 4th enabled shift only.
        v = '{rst: 1'b0, en: 1'b1, mode: 2'b11, sdr: 1'b0, sdl: 1'b0, rot: 1'b0,
              pd: 4'b0000, esr: 4'b0000, ecnt: 2'd0, edone: 1'b0};
        applyStimulus(v, "gap_load");
        for (int k = 0; k < 4; k++) begin
            v.mode = 2'b01; v.sdr = 1'b1; v.en = 1'b1;
            v.esr  = 4'b1111 << (3 - k);
            v.ecnt = 2'(k + 1);
            v.edone = (k == 3);
            applyStimulus(v, $sformatf("gap_shift%0d", k));
            v.en = 1'b0; v.edone = 1'b0;
            applyStimulus(v, $sformatf("gap_idle%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
